me_search_controller: RTL and testbench
=======================================

# me_search_controller

Parametrised full-search motion-estimation sequencer for the inter-prediction path. After a start pulse, it loads the current and search pixel register arrays. It then raster-scans every candidate position of the search window and tracks the minimum SAD returned by the SAD datapath. It reports the best motion vector with a done pulse. It succeeds the fixed 16-cycle load controller and adds candidate sweep, SAD-latency alignment, best-match tracking, abort and error flagging.

## Interface
- MACRO_DIM, 16, macroblock edge in pixels; LOAD length in cycles
- SEARCH_DIM, 48, search-window edge in pixels
- SAD_W, 16, SAD width in bits; must satisfy 2^SAD_W > MACRO_DIM²·255
- SAD_LAT, 4, fixed latency in cycles from cand_valid to the matching sad_valid; ≥1
- Derived: RANGE = SEARCH_DIM−MACRO_DIM+1 (33); CW = $clog2(RANGE); MV_W = CW+1; OFS = (RANGE−1)/2
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin search; honoured only in IDLE
- abort  in  1  cancel search; honoured in any non-IDLE state
- sad_valid  in  1  SAD sample strobe from the datapath
- sad  in  SAD_W  SAD of the candidate issued SAD_LAT cycles earlier
- en_cpr  out  1  current-pixel register load enable
- en_spr  out  1  search-pixel register load/shift enable
- cand_valid  out  1  candidate position issued this cycle
- cand_x, cand_y  out  CW each  candidate offset within the window, 0..RANGE−1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the result is final
- best_mv_x, best_mv_y  out  MV_W signed  best vector = coordinate − OFS
- best_sad  out  SAD_W  minimum SAD found
- err  out  1  sticky SAD-alignment error; cleared by start or reset

## Operation
- States: IDLE → LOAD → SEARCH → DRAIN → DONE → IDLE.
- IDLE: all strobes low. start=1 moves to LOAD, clears err, and arms the first-candidate flag.
- LOAD: en_cpr=en_spr=1 for exactly MACRO_DIM cycles (load counter 0..MACRO_DIM−1), then SEARCH.
- SEARCH: en_spr=1, cand_valid=1 every cycle. cand_x increments and wraps RANGE−1→0; cand_y increments on each wrap. After (RANGE−1,RANGE−1) the block goes to DRAIN. SEARCH takes RANGE² cycles.
- DRAIN: SAD_LAT cycles with no candidates, then DONE.
- DONE: done=1 for one cycle, then IDLE.
- Alignment: a SAD_LAT-deep shift register carries {cand_valid, cand_x, cand_y}.
  - Tail valid and sad_valid both high: compare and update.
  - Either one high without the other: set err and skip the compare.
- Update rule: the first aligned sample of a search loads unconditionally. Later samples load only when sad < best_sad (strictly less). Ties keep the earlier raster position.
- best_mv = {cand_x−OFS, cand_y−OFS}, sign-extended to MV_W.
- Best outputs hold their values until the next accepted start.
- abort, in any non-IDLE state: next state IDLE. The delay line is cleared, no done pulse is issued, and the best outputs are left undefined-but-stable.
- start while busy: ignored. start and abort together in IDLE: start wins. abort together with DONE: done is still issued.

## Timing
- All outputs are registered.
- Reset values: en_cpr=en_spr=cand_valid=busy=done=err=0, cand_x=cand_y=0, best_mv_x=best_mv_y=0, best_sad=all-ones.
- Start sampled at edge E0:
  - LOAD during E0..E(MACRO_DIM−1).
  - SEARCH from E(MACRO_DIM) for RANGE² cycles.
  - DRAIN from E(MACRO_DIM+RANGE²).
  - done is high in the cycle after E(MACRO_DIM+RANGE²+SAD_LAT) = E1109 at the defaults.
- The best outputs are final in the cycle done is high.
- Next start is accepted at the edge after done falls, i.e. one IDLE cycle minimum.
- Reset mid-operation: everything returns to reset values at the next edge.

## Structure
- Package me_pkg holds the state enum, the derived constants RANGE/CW/MV_W/OFS, and a typedef for the signed MV.
- Sub-module me_align_pipe: a parametrised SAD_LAT-stage valid+coordinate delay line with synchronous clear.

## Test plan
- Defaults, sad = 1000 everywhere except 5 at (cand 20,9) → done at E1109, best_mv=(+4,−7), best_sad=5, err=0.
- All SADs equal 77 → best_mv=(−16,−16), i.e. the first candidate wins ties.
- LOAD window → en_cpr high for exactly 16 cycles. cand_valid high for exactly 1089 cycles, and the cand_x wrap occurs every 33 cycles.
- abort at SEARCH cycle 500 → busy low next cycle, no done. A new start then completes normally with the correct result.
- sad_valid dropped for one candidate → err=1 sticky through done; the following start clears err.
- rst_n low mid-DRAIN → all outputs at reset values next cycle. start during busy is ignored and the done timing is unchanged.

Source files
------------

// File: rtl/me_pkg.sv
// Shared types and default-derived constants for the full-search motion-estimation sequencer.
package me_pkg;

    localparam int MACRO_DIM_DEF  = 16;
    localparam int SEARCH_DIM_DEF = 48;
    localparam int SAD_W_DEF      = 16;
    localparam int SAD_LAT_DEF    = 4;

    localparam int RANGE = SEARCH_DIM_DEF - MACRO_DIM_DEF + 1;
    localparam int CW    = $clog2(RANGE);
    localparam int MV_W  = CW + 1;
    localparam int OFS   = (RANGE - 1) / 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SEARCH = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } me_state_e;

    typedef logic signed [MV_W-1:0] me_mv_t;

endpackage

// File: rtl/me_search_controller_if.sv
// Handshake bundle between the search sequencer (master) and the pixel/SAD datapath (slave).
import me_pkg::*;

interface me_search_controller_if #(
    parameter int IF_SAD_W = SAD_W_DEF,
    parameter int IF_CW    = CW,
    parameter int IF_MV_W  = MV_W
);
    logic                       start;
    logic                       abort;
    logic                       sad_valid;
    logic [IF_SAD_W-1:0]        sad;
    logic                       en_cpr;
    logic                       en_spr;
    logic                       cand_valid;
    logic [IF_CW-1:0]           cand_x;
    logic [IF_CW-1:0]           cand_y;
    logic                       busy;
    logic                       done;
    logic signed [IF_MV_W-1:0]  best_mv_x;
    logic signed [IF_MV_W-1:0]  best_mv_y;
    logic [IF_SAD_W-1:0]        best_sad;
    logic                       err;

    modport master (
        input  start, abort, sad_valid, sad,
        output en_cpr, en_spr, cand_valid, cand_x, cand_y, busy, done,
               best_mv_x, best_mv_y, best_sad, err
    );

    modport slave (
        output start, abort, sad_valid, sad,
        input  en_cpr, en_spr, cand_valid, cand_x, cand_y, busy, done,
               best_mv_x, best_mv_y, best_sad, err
    );
endinterface

// File: rtl/me_align_pipe.sv
// Delay line carrying {valid, x, y} of each issued candidate so it lines up with the returning SAD.
module me_align_pipe #(
    parameter int DEPTH = 4,
    parameter int CW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [CW-1:0] in_x,
    input  logic [CW-1:0] in_y,
    output logic          out_valid,
    output logic [CW-1:0] out_x,
    output logic [CW-1:0] out_y
);
    localparam int SW = 2 * CW + 1;

    logic [SW-1:0] stage_q [DEPTH];
    logic [SW-1:0] stage_d [DEPTH];

    // Next-stage values: shift by one, or flush everything on clear
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = '0;
        end
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = '0;
            end
        end else begin
            stage_d[0] = {in_valid, in_x, in_y};
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Stage registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign out_valid = stage_q[DEPTH-1][SW-1];
    assign out_x     = stage_q[DEPTH-1][2*CW-1:CW];
    assign out_y     = stage_q[DEPTH-1][CW-1:0];
endmodule

// File: rtl/me_search_controller.sv
// Full-search ME sequencer: load pixel arrays, raster-sweep all candidates, track the minimum SAD.
module me_search_controller
    import me_pkg::*;
#(
    parameter int MACRO_DIM  = MACRO_DIM_DEF,
    parameter int SEARCH_DIM = SEARCH_DIM_DEF,
    parameter int SAD_W      = SAD_W_DEF,
    parameter int SAD_LAT    = SAD_LAT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    me_search_controller_if.master bus
);
    localparam int R_LEN = SEARCH_DIM - MACRO_DIM + 1;
    localparam int C_W   = $clog2(R_LEN);
    localparam int M_W   = C_W + 1;
    localparam int OFS_V = (R_LEN - 1) / 2;
    localparam int CNT_W = $clog2((MACRO_DIM > SAD_LAT) ? MACRO_DIM : SAD_LAT) + 1;
    localparam logic [C_W-1:0]   LAST     = C_W'(R_LEN - 1);
    localparam logic [CNT_W-1:0] LOAD_END = CNT_W'(MACRO_DIM - 1);
    localparam logic [CNT_W-1:0] DRN_END  = CNT_W'(SAD_LAT - 1);

    me_state_e               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [C_W-1:0]          cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic                    en_cpr_q, en_cpr_d, en_spr_q, en_spr_d;
    logic                    cand_valid_q, cand_valid_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic                    err_q, err_d, first_q, first_d;
    logic signed [M_W-1:0]   best_x_q, best_x_d, best_y_q, best_y_d;
    logic [SAD_W-1:0]        best_sad_q, best_sad_d;

    logic                    abort_take_s;
    logic                    tail_v_s;
    logic [C_W-1:0]          tail_x_s, tail_y_s;

    assign abort_take_s = bus.abort && (state_q != ST_IDLE);

    me_align_pipe #(
        .DEPTH (SAD_LAT),
        .CW    (C_W)
    ) u_align (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (abort_take_s),
        .in_valid  (cand_valid_q),
        .in_x      (cand_x_q),
        .in_y      (cand_y_q),
        .out_valid (tail_v_s),
        .out_x     (tail_x_s),
        .out_y     (tail_y_s)
    );

    // Next state, sweep counters, best-match tracking and registered-output precompute
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_x_d   = cand_x_q;
        cand_y_d   = cand_y_q;
        err_d      = err_q;
        first_d    = first_q;
        best_x_d   = best_x_q;
        best_y_d   = best_y_q;
        best_sad_d = best_sad_q;

        // A SAD sample is only meaningful when it lines up with an issued candidate
        if (tail_v_s && bus.sad_valid) begin
            if (first_q || (bus.sad < best_sad_q)) begin
                first_d    = 1'b0;
                best_sad_d = bus.sad;
                best_x_d   = $signed({1'b0, tail_x_s}) - $signed(M_W'(OFS_V));
                best_y_d   = $signed({1'b0, tail_y_s}) - $signed(M_W'(OFS_V));
            end else begin
                first_d = first_q;
            end
        end else if (tail_v_s || bus.sad_valid) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_LOAD;
                    cnt_d    = '0;
                    cand_x_d = '0;
                    cand_y_d = '0;
                    err_d    = 1'b0;
                    first_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cnt_q == LOAD_END) begin
                    state_d = ST_SEARCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SEARCH: begin
                if (cand_x_q == LAST) begin
                    cand_x_d = '0;
                    if (cand_y_q == LAST) begin
                        cand_y_d = '0;
                        state_d  = ST_DRAIN;
                        cnt_d    = '0;
                    end else begin
                        cand_y_d = cand_y_q + C_W'(1);
                    end
                end else begin
                    cand_x_d = cand_x_q + C_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRN_END) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_take_s) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            cand_x_d = '0;
            cand_y_d = '0;
        end else begin
            cnt_d = cnt_d;
        end

        en_cpr_d     = (state_d == ST_LOAD);
        en_spr_d     = (state_d == ST_LOAD) || (state_d == ST_SEARCH);
        cand_valid_d = (state_d == ST_SEARCH);
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            en_cpr_q     <= 1'b0;
            en_spr_q     <= 1'b0;
            cand_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            first_q      <= 1'b0;
            best_x_q     <= '0;
            best_y_q     <= '0;
            best_sad_q   <= '1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            en_cpr_q     <= en_cpr_d;
            en_spr_q     <= en_spr_d;
            cand_valid_q <= cand_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            first_q      <= first_d;
            best_x_q     <= best_x_d;
            best_y_q     <= best_y_d;
            best_sad_q   <= best_sad_d;
        end
    end

    assign bus.en_cpr     = en_cpr_q;
    assign bus.en_spr     = en_spr_q;
    assign bus.cand_valid = cand_valid_q;
    assign bus.cand_x     = cand_x_q;
    assign bus.cand_y     = cand_y_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.best_mv_x  = best_x_q;
    assign bus.best_mv_y  = best_y_q;
    assign bus.best_sad   = best_sad_q;
endmodule

// File: tb/tb_me_search_controller.sv
// Directed + randomized bench: datapath model returns table SADs with fixed latency; best match from a raster argmin.
module tb_me_search_controller;
    import me_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    me_search_controller_if ifc ();
    me_search_controller dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

    int total = 0;
    int bad   = 0;
    int done_n, ncpr, nval, rbad, err_after_start;
    int drop_en = 0, drop_x = 0, drop_y = 0;
    logic [15:0] tbl [33][33];
    bit  pv [5];
    int  px [5];
    int  py [5];

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample after the edge, then present the SAD of the candidate issued 4 cycles ago
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 4; i > 0; i--) begin
            pv[i] = pv[i-1]; px[i] = px[i-1]; py[i] = py[i-1];
        end
        pv[0] = ifc.cand_valid; px[0] = int'(ifc.cand_x); py[0] = int'(ifc.cand_y);
        ifc.sad_valid = pv[4] && !(drop_en != 0 && px[4] == drop_x && py[4] == drop_y);
        ifc.sad       = pv[4] ? tbl[px[4]][py[4]] : 16'd0;
    endtask

    task automatic flush_dp();
        for (int i = 0; i < 5; i++) pv[i] = 1'b0;
        ifc.sad_valid = 1'b0;
        ifc.sad       = 16'd0;
    endtask

    task automatic model(output int bx, output int by, output int bs);
        bs = -1; bx = 0; by = 0;
        for (int y = 0; y < 33; y++)
            for (int x = 0; x < 33; x++)
                if (!(drop_en != 0 && x == drop_x && y == drop_y))
                    if (bs < 0 || int'(tbl[x][y]) < bs) begin
                        bs = int'(tbl[x][y]); bx = x; by = y;
                    end
    endtask

    task automatic run_search(input int abort_n, input int rst_at, input int dup);
        int n = 0;
        done_n = -1; ncpr = 0; nval = 0; rbad = 0;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        err_after_start = int'(ifc.err);
        while (1) begin
            if (ifc.en_cpr) ncpr++;
            if (ifc.cand_valid) begin
                if (int'(ifc.cand_x) != nval % 33 || int'(ifc.cand_y) != nval / 33) rbad++;
                nval++;
            end
            if (ifc.done) begin done_n = n; break; end
            if (n == 1400) break;
            ifc.start = (n + 1 == dup);
            ifc.abort = (n + 1 == abort_n);
            rst_n     = (n + 1 != rst_at);
            tick();
            n++;
            ifc.start = 1'b0; ifc.abort = 1'b0; rst_n = 1'b1;
            if (n == abort_n || n == rst_at) break;
        end
    endtask

    task automatic search_and_check(input int dup);
        int bx, by, bs;
        model(bx, by, bs);
        run_search(-1, -1, dup);
        chk("done_cycle", done_n, 1109);
        chk("best_mv_x", ifc.best_mv_x, bx - 16);
        chk("best_mv_y", ifc.best_mv_y, by - 16);
        chk("best_sad", ifc.best_sad, bs);
        chk("err_at_done", ifc.err, drop_en);
        chk("en_cpr_cycles", ncpr, 16);
        chk("cand_cycles", nval, 1089);
        chk("raster_order", rbad, 0);
        tick();
        chk("done_pulse_width", ifc.done, 0);
        chk("busy_after_done", ifc.busy, 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_en_cpr", ifc.en_cpr, 0);
        chk("rst_en_spr", ifc.en_spr, 0);
        chk("rst_cand_valid", ifc.cand_valid, 0);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_done", ifc.done, 0);
        chk("rst_err", ifc.err, 0);
        chk("rst_cand_x", ifc.cand_x, 0);
        chk("rst_cand_y", ifc.cand_y, 0);
        chk("rst_mv_x", ifc.best_mv_x, 0);
        chk("rst_mv_y", ifc.best_mv_y, 0);
        chk("rst_best_sad", ifc.best_sad, 16'hFFFF);
    endtask

    task automatic fill_rand(input int lo, input int hi);
        for (int x = 0; x < 33; x++)
            for (int y = 0; y < 33; y++)
                tbl[x][y] = 16'($urandom_range(hi, lo));
    endtask

    initial begin
        int seen;
        ifc.start = 1'b0; ifc.abort = 1'b0; ifc.sad_valid = 1'b0; ifc.sad = 16'd0;
        rst_n = 1'b0;
        flush_dp();
        repeat (3) tick();
        chk_reset_vals();
        rst_n = 1'b1;
        tick();

        // Single minimum at candidate (20,9), with a start pulse mid-search that must be ignored
        for (int x = 0; x < 33; x++) for (int y = 0; y < 33; y++) tbl[x][y] = 16'd1000;
        tbl[20][9] = 16'd5;
        search_and_check(300);
        chk("single_min_mv_x", ifc.best_mv_x, 4);
        chk("single_min_mv_y", ifc.best_mv_y, -7);

        // Flat surface: first raster candidate wins every tie
        for (int x = 0; x < 33; x++) for (int y = 0; y < 33; y++) tbl[x][y] = 16'd77;
        search_and_check(-1);
        chk("tie_mv_x", ifc.best_mv_x, -16);
        chk("tie_mv_y", ifc.best_mv_y, -16);

        // Random surfaces, narrow value range so ties are frequent
        for (int r = 0; r < 3; r++) begin
            fill_rand(50, 400 + r * 2000);
            search_and_check(-1);
        end

        // Abort at search cycle 500: idle next cycle, no done; then a clean search
        fill_rand(100, 5000);
        run_search(516, -1, -1);
        chk("abort_busy", ifc.busy, 0);
        chk("abort_cand_valid", ifc.cand_valid, 0);
        flush_dp();
        seen = 0;
        for (int i = 0; i < 1200; i++) begin
            tick();
            if (ifc.done) seen++;
        end
        chk("abort_no_done", seen, 0);
        search_and_check(-1);

        // One SAD strobe dropped: sticky error through done, cleared by the next start
        fill_rand(100, 5000);
        drop_en = 1; drop_x = int'($urandom_range(32, 0)); drop_y = int'($urandom_range(32, 0));
        search_and_check(-1);
        repeat (3) tick();
        chk("err_sticky", ifc.err, 1);
        drop_en = 0;
        search_and_check(-1);
        chk("err_cleared_by_start", err_after_start, 0);

        // Reset asserted during DRAIN
        fill_rand(100, 5000);
        run_search(-1, 1107, -1);
        chk_reset_vals();
        flush_dp();
        tick();
        search_and_check(-1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
